// File: rtl/highest_match_tracker.sv
// Streaming highest-match tracker: finds the longest match bit per beat and keeps the
// best one across a frame, emitting one registered result per frame.
module highest_match_tracker #(
    parameter int WIDTH = 17,
    parameter int LEN_W = 8,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] equals,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [LEN_W-1:0] best_len,
    output logic [IDX_W-1:0] best_idx,
    output logic             found,
    output logic             overflow
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [LEN_W-1:0] LEN_NONE = {LEN_W{1'b1}};
    localparam logic [IDX_W-1:0] IDX_MAX  = {IDX_W{1'b1}};
    localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};

    // Returns {hit, index of highest set bit}; index is all-ones when nothing is set.
    function automatic logic [LEN_W:0] encode_high(input logic [WIDTH-1:0] vec);
        logic [LEN_W:0] res;
        res = {1'b0, LEN_NONE};
        for (int i = 0; i < WIDTH; i++) begin
            if (vec[i]) begin
                res = {1'b1, LEN_W'(i)};
            end
        end
        return res;
    endfunction

    logic [1:0]       state_r;
    logic [LEN_W-1:0] best_len_r;
    logic [IDX_W-1:0] best_idx_r;
    logic             found_r;
    logic             overflow_r;
    logic [IDX_W-1:0] cnt_r;
    logic             sat_r;

    logic [LEN_W:0]   enc_s;
    logic             in_ready_s;
    logic             accept_s;
    logic             take_s;

    // Per-beat encode and the strictly-greater update decision (ties keep the earlier beat).
    always_comb begin
        enc_s      = encode_high(equals);
        in_ready_s = (state_r != ST_DONE);
        accept_s   = in_valid && in_ready_s;
        take_s     = 1'b0;
        if (enc_s[LEN_W] && (!found_r || (enc_s[LEN_W-1:0] > best_len_r))) begin
            take_s = 1'b1;
        end else begin
            take_s = 1'b0;
        end
    end

    // Frame FSM, accumulators and saturating beat counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            best_len_r <= LEN_NONE;
            best_idx_r <= IDX_ZERO;
            found_r    <= 1'b0;
            overflow_r <= 1'b0;
            cnt_r      <= IDX_ZERO;
            sat_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_ACCUM: begin
                    if (accept_s) begin
                        if (take_s) begin
                            best_len_r <= enc_s[LEN_W-1:0];
                            best_idx_r <= cnt_r;
                            found_r    <= 1'b1;
                        end
                        // sat_r means all index slots are used: this beat is one too many.
                        if (sat_r) begin
                            overflow_r <= 1'b1;
                        end
                        if (in_last) begin
                            cnt_r   <= IDX_ZERO;
                            sat_r   <= 1'b0;
                            state_r <= ST_DONE;
                        end else begin
                            state_r <= ST_ACCUM;
                            if (cnt_r == IDX_MAX) begin
                                sat_r <= 1'b1;
                            end else begin
                                cnt_r <= cnt_r + IDX_ONE;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_r    <= ST_IDLE;
                        best_len_r <= LEN_NONE;
                        best_idx_r <= IDX_ZERO;
                        found_r    <= 1'b0;
                        overflow_r <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = (state_r == ST_DONE);
    assign best_len  = best_len_r;
    assign best_idx  = best_idx_r;
    assign found     = found_r;
    assign overflow  = overflow_r;

endmodule

// File: tb/tb_highest_match_tracker.sv
// Self-checking bench for highest_match_tracker: directed frames plus random frames
// compared against a frame-level reference model.
module tb_highest_match_tracker;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [16:0] equals;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  best_len;
    logic [3:0]  best_idx;
    logic        found;
    logic        overflow;

    int checks_cnt = 0;
    int errors_cnt = 0;

    logic [16:0] frame_q[$];

    highest_match_tracker #(.WIDTH(17), .LEN_W(8), .IDX_W(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .equals(equals), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
        .best_len(best_len), .best_idx(best_idx), .found(found), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int high_bit(input logic [16:0] v);
        int r = -1;
        for (int i = 0; i < 17; i++) if (v[i]) r = i;
        return r;
    endfunction

    // Reference: longest match wins, earliest beat on ties, index capped at 15, >16 beats overflows.
    task automatic model(output int e_len, output int e_idx, output int e_found, output int e_ovf);
        int best = -1;
        int idx = 0;
        foreach (frame_q[k]) begin
            int h = high_bit(frame_q[k]);
            if (h > best) begin
                best = h;
                idx  = (k > 15) ? 15 : k;
            end
        end
        e_found = (best >= 0) ? 1 : 0;
        e_len   = (best >= 0) ? best : 255;
        e_idx   = idx;
        e_ovf   = (frame_q.size() > 16) ? 1 : 0;
    endtask

    // Called at a negedge; returns at the negedge after the beat is accepted.
    task automatic send_beat(input logic [16:0] eq, input logic last);
        int n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check_val("in_ready_timeout", 32'd0, 32'd1);
        end else begin
            in_valid = 1'b1;
            equals   = eq;
            in_last  = last;
            @(negedge clk);
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
    endtask

    task automatic run_frame(input string tag, input int hold, input bit poke);
        int e_len, e_idx, e_found, e_ovf;
        foreach (frame_q[k]) send_beat(frame_q[k], (k == frame_q.size() - 1));
        model(e_len, e_idx, e_found, e_ovf);
        check_val({tag, "_valid"}, 32'(out_valid), 32'd1);
        check_val({tag, "_len"}, 32'(best_len), 32'(e_len));
        check_val({tag, "_idx"}, 32'(best_idx), 32'(e_idx));
        check_val({tag, "_found"}, 32'(found), 32'(e_found));
        check_val({tag, "_ovf"}, 32'(overflow), 32'(e_ovf));
        for (int c = 0; c < hold; c++) begin
            if (poke) begin
                in_valid = 1'b1;
                equals   = 17'h1FFFF;
                in_last  = 1'b1;
            end
            @(negedge clk);
            check_val({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            check_val({tag, "_hold_ready"}, 32'(in_ready), 32'd0);
            check_val({tag, "_hold_len"}, 32'(best_len), 32'(e_len));
            check_val({tag, "_hold_idx"}, 32'(best_idx), 32'(e_idx));
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_val({tag, "_released"}, 32'(out_valid), 32'd0);
        check_val({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; equals = 17'h0; in_last = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_val("rst_valid", 32'(out_valid), 32'd0);
        check_val("rst_len", 32'(best_len), 32'd255);
        check_val("rst_idx", 32'(best_idx), 32'd0);
        check_val("rst_found", 32'(found), 32'd0);
        check_val("rst_ovf", 32'(overflow), 32'd0);
        check_val("rst_ready", 32'(in_ready), 32'd1);
        reset = 1'b0;
        @(negedge clk);

        frame_q = '{17'h00010};
        run_frame("single", 0, 1'b0);
        frame_q = '{17'h00004, 17'h10000, 17'h00100};
        run_frame("three", 0, 1'b0);
        frame_q = '{17'h00000, 17'h00000};
        run_frame("none", 0, 1'b0);
        frame_q = '{17'h00020, 17'h00020};
        run_frame("tie", 0, 1'b0);
        frame_q = '{17'h00003, 17'h00040};
        run_frame("stall", 5, 1'b1);

        // Reset during an unfinished frame discards it.
        send_beat(17'h00400, 1'b0);
        send_beat(17'h00800, 1'b0);
        reset = 1'b1;
        #1;
        check_val("midrst_valid", 32'(out_valid), 32'd0);
        check_val("midrst_len", 32'(best_len), 32'd255);
        check_val("midrst_ovf", 32'(overflow), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        frame_q = '{17'h00000, 17'h00001};
        run_frame("after_rst", 0, 1'b0);

        frame_q.delete();
        for (int k = 0; k < 16; k++) frame_q.push_back(17'(1 << (k % 16)));
        run_frame("sixteen", 0, 1'b0);
        frame_q.delete();
        for (int k = 0; k < 16; k++) frame_q.push_back(17'h00002);
        frame_q.push_back(17'h10000);
        run_frame("overflow", 1, 1'b0);

        for (int f = 0; f < 40; f++) begin
            int n = $urandom_range(1, 20);
            frame_q.delete();
            for (int k = 0; k < n; k++) begin
                int mode = $urandom_range(0, 3);
                if (mode == 0) frame_q.push_back(17'h0);
                else if (mode == 1) frame_q.push_back(17'(1 << $urandom_range(0, 16)));
                else if (mode == 2) frame_q.push_back(17'($urandom) & 17'h000FF);
                else frame_q.push_back(17'($urandom));
            end
            run_frame("rand", $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
